// File: rtl/exe_bru_bht_if.sv
// rtl/exe_bru_bht_if.sv - EX branch unit / BHT signal bundle
`ifndef BRUCTL_WIDTH
`define BRUCTL_WIDTH 4
`define BRUCTL_BEQ   4'd1
`define BRUCTL_BNE   4'd2
`define BRUCTL_BLT   4'd3
`define BRUCTL_BGE   4'd4
`define BRUCTL_BLTU  4'd5
`define BRUCTL_BGEU  4'd6
`define BRUCTL_JAL   4'd7
`define BRUCTL_JALR  4'd8
`endif

interface exe_bru_bht_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]          I_if_pc;
  logic                     O_if_pred_taken;
  logic                     I_ex_valid;
  logic                     I_flush;
  logic [XLEN-1:0]          I_ex_pc;
  logic [XLEN-1:0]          I_alu_srca;
  logic [XLEN-1:0]          I_alu_srcb;
  logic [`BRUCTL_WIDTH-1:0] I_bru_ctrl;
  logic [XLEN-1:0]          I_ex_target;
  logic                     I_pred_taken;
  logic [XLEN-1:0]          I_pred_target;
  logic                     O_bru_taken;
  logic                     O_redirect_valid;
  logic [XLEN-1:0]          O_redirect_pc;
  logic [CNT_W-1:0]         O_br_cnt;
  logic [CNT_W-1:0]         O_mis_cnt;

  modport master (
    output I_if_pc, I_ex_valid, I_flush, I_ex_pc, I_alu_srca, I_alu_srcb,
           I_bru_ctrl, I_ex_target, I_pred_taken, I_pred_target,
    input  O_if_pred_taken, O_bru_taken, O_redirect_valid, O_redirect_pc,
           O_br_cnt, O_mis_cnt
  );

  modport slave (
    input  I_if_pc, I_ex_valid, I_flush, I_ex_pc, I_alu_srca, I_alu_srcb,
           I_bru_ctrl, I_ex_target, I_pred_taken, I_pred_target,
    output O_if_pred_taken, O_bru_taken, O_redirect_valid, O_redirect_pc,
           O_br_cnt, O_mis_cnt
  );
endinterface

// File: rtl/exe_bru_bht.sv
// rtl/exe_bru_bht.sv - EX-stage branch resolve, redirect, 2-bit BHT and perf counters
`ifndef BRUCTL_WIDTH
`define BRUCTL_WIDTH 4
`define BRUCTL_BEQ   4'd1
`define BRUCTL_BNE   4'd2
`define BRUCTL_BLT   4'd3
`define BRUCTL_BGE   4'd4
`define BRUCTL_BLTU  4'd5
`define BRUCTL_BGEU  4'd6
`define BRUCTL_JAL   4'd7
`define BRUCTL_JALR  4'd8
`endif

module exe_bru_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic          I_clk,
  input  logic          I_rst_n,
  exe_bru_bht_if.slave  bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic             taken;
  logic             is_br;
  logic             is_cond;
  logic             act;
  logic             mis;
  logic [XLEN-1:0]  next_pc;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       cur_ctr;
  logic [1:0]       new_ctr;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;

  // Resolve direction and classify the opcode
  always_comb begin
    taken   = 1'b0;
    is_br   = 1'b1;
    is_cond = 1'b1;
    case (bus.I_bru_ctrl)
      `BRUCTL_BEQ:  taken = (bus.I_alu_srca == bus.I_alu_srcb);
      `BRUCTL_BNE:  taken = (bus.I_alu_srca != bus.I_alu_srcb);
      `BRUCTL_BLT:  taken = ($signed(bus.I_alu_srca) < $signed(bus.I_alu_srcb));
      `BRUCTL_BGE:  taken = !($signed(bus.I_alu_srca) < $signed(bus.I_alu_srcb));
      `BRUCTL_BLTU: taken = (bus.I_alu_srca < bus.I_alu_srcb);
      `BRUCTL_BGEU: taken = !(bus.I_alu_srca < bus.I_alu_srcb);
      `BRUCTL_JAL, `BRUCTL_JALR: begin
        taken   = 1'b1;
        is_cond = 1'b0;
      end
      default: begin
        is_br   = 1'b0;
        is_cond = 1'b0;
      end
    endcase
  end

  assign act     = bus.I_ex_valid & ~bus.I_flush & is_br;
  assign next_pc = taken ? bus.I_ex_target : bus.I_ex_pc + XLEN'(4);
  assign mis     = act & ((bus.I_pred_taken != taken) |
                          (taken & (bus.I_pred_target != bus.I_ex_target)));

  assign if_idx  = bus.I_if_pc[IDX_W+1:2];
  assign ex_idx  = bus.I_ex_pc[IDX_W+1:2];
  assign cur_ctr = bht[ex_idx];

  // Saturating 2-bit counter step toward the resolved direction
  always_comb begin
    new_ctr = cur_ctr;
    if (taken) begin
      if (cur_ctr != 2'b11) new_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) new_ctr = cur_ctr - 2'b01;
    end
  end

  // BHT storage: reset to weak not-taken, trained only by live conditional branches
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (act && is_cond) begin
      bht[ex_idx] <= new_ctr;
    end
  end

  // Registered one-cycle redirect; the target is held between pulses
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mis;
      if (mis) redirect_pc <= next_pc;
    end
  end

  // Performance counters, free-running with natural wrap
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (act) br_cnt  <= br_cnt + CNT_W'(1);
      if (mis) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

  assign bus.O_if_pred_taken  = bht[if_idx][1];
  assign bus.O_bru_taken      = taken;
  assign bus.O_redirect_valid = redirect_valid;
  assign bus.O_redirect_pc    = redirect_pc;
  assign bus.O_br_cnt         = br_cnt;
  assign bus.O_mis_cnt        = mis_cnt;
endmodule
